frame_sequencer: RTL and testbench

Controller that sequences writes into the 1024 x 12 telemetry frame RAM.
- Splits the RAM into two ping-pong pages of FRAME_LEN words.
- Opens each page with 4 sync-marker words, then fills it with data words from the word source.
- Hands finished pages to the downstream reader with a full/done handshake.
- Rotates the marker set 0,1,2,3,0... frame by frame, giving the M/B, nM/B, M/nB, nM/nB sequence.

---
 rtl/dtfm_pkg.sv | 26 ++
 rtl/frame_sequencer_page_owner.sv | 30 +++
 rtl/frame_sequencer.sv | 125 ++++++++++++
 tb/tb_frame_sequencer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtfm_pkg.sv
// Shared definitions for the frame sequencer: sync-marker constants, the
// 16-entry marker table indexed by {set, word}, and the FSM state type.
package dtfm_pkg;

   localparam int MARK_WORDS = 4;

   localparam logic [21:0] MARK_M  = {11'h7CD, 11'h0D2};
   localparam logic [21:0] MARK_NM = ~MARK_M;
   localparam logic [21:0] MARK_B  = {11'h10E, 11'h735};
   localparam logic [21:0] MARK_NB = ~MARK_B;

   // Set s opens with M or nM (chosen by s[0]) followed by B or nB (chosen by s[1]).
   localparam logic [0:15][10:0] MARK_TABLE = {
      MARK_M,  MARK_B,
      MARK_NM, MARK_B,
      MARK_M,  MARK_NB,
      MARK_NM, MARK_NB
   };

   typedef enum logic [1:0] {MARK, DATA, SWAP, WAIT} state_t;

   function automatic logic [10:0] mark_word(input logic [1:0] set, input logic [1:0] i);
      return MARK_TABLE[{set, i}];
   endfunction

endpackage

// File: rtl/frame_sequencer_page_owner.sv
// Tracks which ping-pong page is held by the reader. Completion sets a page,
// reader release clears it (set wins on a tie); the free query sees the same-cycle update.
module page_owner (
   input  logic clk,
   input  logic reset,
   input  logic set,
   input  logic set_page,
   input  logic clr,
   input  logic clr_page,
   input  logic query_page,
   output logic query_free
);

   logic [1:0] busy;
   logic [1:0] busy_nxt;

   always_comb begin
      busy_nxt = busy;
      if (clr) busy_nxt[clr_page] = 1'b0;
      if (set) busy_nxt[set_page] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) busy <= 2'b00;
      else       busy <= busy_nxt;
   end

   assign query_free = ~busy_nxt[query_page];

endmodule

// File: rtl/frame_sequencer.sv
// Writes 4 sync markers then data words into alternating RAM pages; 1-cycle write latency.
// Words arriving outside DATA wait in a 1-entry skid; overflow is dropped and counted.
module frame_sequencer
   import dtfm_pkg::*;
#(
   parameter int FRAME_LEN = 512,
   parameter int ADDR_W    = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       word,
   input  logic              ready,
   input  logic              rd_done,
   input  logic              rd_page,
   output logic [11:0]       outWDAT,
   output logic              outWREN,
   output logic [ADDR_W-1:0] outWADR,
   output logic              page_full,
   output logic              page_sel,
   output logic [1:0]        mark_set,
   output logic [7:0]        drop_cnt
);

   localparam logic [ADDR_W-1:0] PAGE_SIZE = ADDR_W'(FRAME_LEN);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(FRAME_LEN - 1);
   localparam logic [ADDR_W-1:0] LAST_MARK = ADDR_W'(MARK_WORDS - 1);

   state_t            state;
   logic [ADDR_W-1:0] idx;
   logic              wpage;
   logic              skid_full;
   logic [11:0]       skid_dat;

   logic [ADDR_W-1:0] wr_addr;
   logic              data_take;
   logic              page_done;
   logic              other_free;
   logic [11:0]       data_word;
   logic              unused_word_hi;

   assign wr_addr        = (wpage ? PAGE_SIZE : '0) + idx;
   assign data_take      = (state == DATA) && (skid_full || ready);
   assign data_word      = skid_full ? skid_dat : word[11:0];
   assign page_done      = data_take && (idx == LAST_IDX);
   assign unused_word_hi = ^word[15:12];

   page_owner u_owner (
      .clk        (clk),
      .reset      (reset),
      .set        (page_done),
      .set_page   (wpage),
      .clr        (rd_done),
      .clr_page   (rd_page),
      .query_page (~wpage),
      .query_free (other_free)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= MARK;
         idx       <= '0;
         wpage     <= 1'b0;
         skid_full <= 1'b0;
         skid_dat  <= '0;
         outWDAT   <= '0;
         outWREN   <= 1'b0;
         outWADR   <= '0;
         page_full <= 1'b0;
         page_sel  <= 1'b0;
         mark_set  <= '0;
         drop_cnt  <= '0;
      end else begin
         outWREN   <= 1'b0;
         page_full <= 1'b0;

         // The skid drains only in DATA, and a strobe in that cycle refills it.
         if (state == DATA) begin
            if (skid_full) skid_full <= ready;
            if (skid_full && ready) skid_dat <= word[11:0];
         end else if (ready) begin
            if (!skid_full) begin
               skid_full <= 1'b1;
               skid_dat  <= word[11:0];
            end else if (drop_cnt != 8'hFF) begin
               drop_cnt <= drop_cnt + 8'd1;
            end
         end

         case (state)
            MARK: begin
               outWREN <= 1'b1;
               outWADR <= wr_addr;
               outWDAT <= {1'b0, mark_word(mark_set, idx[1:0])};
               idx     <= idx + 1'b1;
               if (idx == LAST_MARK) state <= DATA;
            end
            DATA: begin
               if (data_take) begin
                  outWREN <= 1'b1;
                  outWADR <= wr_addr;
                  outWDAT <= data_word;
                  idx     <= idx + 1'b1;
                  if (page_done) begin
                     page_full <= 1'b1;
                     page_sel  <= wpage;
                     state     <= SWAP;
                  end
               end
            end
            SWAP, WAIT: begin
               if (other_free) begin
                  wpage    <= ~wpage;
                  mark_set <= mark_set + 2'd1;
                  idx      <= '0;
                  state    <= MARK;
               end else begin
                  state <= WAIT;
               end
            end
            default: state <= MARK;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer with 8-word pages: expected RAM writes are queued as
// stimulus is driven and compared in order by a write monitor.
module tb_frame_sequencer;

   localparam int FL = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] word;
   logic        ready;
   logic        rd_done;
   logic        rd_page;
   logic [11:0] outWDAT;
   logic        outWREN;
   logic [9:0]  outWADR;
   logic        page_full;
   logic        page_sel;
   logic [1:0]  mark_set;
   logic [7:0]  drop_cnt;

   typedef struct packed {
      logic [9:0]  addr;
      logic [11:0] dat;
   } wr_t;

   wr_t sb[$];
   wr_t mon_e;
   int  checks   = 0;
   int  failures = 0;

   always #5 clk = ~clk;

   frame_sequencer #(.FRAME_LEN(FL), .ADDR_W(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .word      (word),
      .ready     (ready),
      .rd_done   (rd_done),
      .rd_page   (rd_page),
      .outWDAT   (outWDAT),
      .outWREN   (outWREN),
      .outWADR   (outWADR),
      .page_full (page_full),
      .page_sel  (page_sel),
      .mark_set  (mark_set),
      .drop_cnt  (drop_cnt)
   );

   // Every RAM write must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (outWREN === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_write addr=%0d dat=%h", outWADR, outWDAT);
         end else begin
            mon_e = sb.pop_front();
            if ({outWADR, outWDAT} !== {mon_e.addr, mon_e.dat}) begin
               failures++;
               $display("FAIL sb_write got addr=%0d dat=%h expected addr=%0d dat=%h",
                        outWADR, outWDAT, mon_e.addr, mon_e.dat);
            end
         end
      end
   end

   function automatic logic [11:0] exp_mark(input int set, input int i);
      logic [10:0] v;
      case (i)
         0:       v = 11'h7CD;
         1:       v = 11'h0D2;
         2:       v = 11'h10E;
         default: v = 11'h735;
      endcase
      if ((i < 2 && (set % 2) == 1) || (i >= 2 && ((set / 2) % 2) == 1)) v = ~v;
      return {1'b0, v};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] w);
      word  = w;
      ready = 1'b1;
      tick();
      ready = 1'b0;
   endtask

   task automatic push_wr(input int addr, input logic [11:0] dat);
      wr_t e;
      e.addr = 10'(addr);
      e.dat  = dat;
      sb.push_back(e);
   endtask

   task automatic push_markers(input int page, input int set);
      for (int i = 0; i < 4; i++) push_wr(page * FL + i, exp_mark(set % 4, i));
   endtask

   task automatic wait_drain(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 60; c++) begin
         if (sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      word    = '0;
      ready   = 1'b0;
      rd_done = 1'b0;
      rd_page = 1'b0;
      tick();
      tick();
      sb.delete();
      reset = 1'b0;
   endtask

   // Waits for queued markers to land, then sends nwords data words.
   task automatic fill_frame(input int page, input int nwords, input int gap, output bit full_ok);
      bit          ok;
      logic [15:0] w;
      wait_drain(ok);
      for (int j = 0; j < nwords; j++) begin
         w = 16'($urandom);
         push_wr(page * FL + 4 + j, w[11:0]);
         send(w);
         if (j < nwords - 1) repeat (gap) tick();
      end
      full_ok = 1'b0;
      if (nwords == FL - 4) begin
         for (int c = 0; c < 20; c++) begin
            if (page_full === 1'b1) begin
               full_ok = 1'b1;
               break;
            end
            tick();
         end
      end
   endtask

   task automatic release_page(input int page);
      rd_done = 1'b1;
      rd_page = 1'(page);
      tick();
      rd_done = 1'b0;
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      word    = '0;
      ready   = 1'b0;
      rd_done = 1'b0;
      rd_page = 1'b0;
      tick();
      tick();
      checks++;
      if ({outWDAT, outWREN, outWADR} !== 23'd0) begin
         failures++;
         $display("FAIL reset_write_port got dat=%h en=%b addr=%0d expected all 0", outWDAT, outWREN, outWADR);
      end
      checks++;
      if ({page_full, page_sel, mark_set, drop_cnt} !== 12'd0) begin
         failures++;
         $display("FAIL reset_status got full=%b sel=%b set=%0d drop=%0d expected all 0",
                  page_full, page_sel, mark_set, drop_cnt);
      end
      sb.delete();
      reset = 1'b0;
   endtask

   task automatic test_first_frame();
      logic [15:0] w;
      bit          ok;
      bit          seen;
      do_reset();
      push_markers(0, 0);
      for (int j = 0; j < 4; j++) begin
         w = 16'($urandom);
         push_wr(4 + j, w[11:0]);
         send(w);
         if (j < 3) repeat (5) tick();
      end
      checks++;
      if (page_full !== 1'b1 || page_sel !== 1'b0 || outWADR !== 10'd7 || mark_set !== 2'd0) begin
         failures++;
         $display("FAIL first_page_full got full=%b sel=%b addr=%0d set=%0d expected 1 0 7 0",
                  page_full, page_sel, outWADR, mark_set);
      end
      push_markers(1, 1);
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         tick();
         if (outWREN === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || outWADR !== 10'd8 || outWDAT !== 12'h032 || mark_set !== 2'd1) begin
         failures++;
         $display("FAIL second_frame_marker got seen=%b addr=%0d dat=%h set=%0d expected 1 8 032 1",
                  seen, outWADR, outWDAT, mark_set);
      end
      wait_drain(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL first_frame_drain got %0d pending writes expected 0", sb.size());
      end
   endtask

   task automatic test_mark_rotation();
      bit full;
      bit ok;
      do_reset();
      for (int f = 0; f < 4; f++) begin
         push_markers(f % 2, f);
         fill_frame(f % 2, FL - 4, 1, full);
         checks++;
         if (!full || page_sel !== 1'(f % 2) || mark_set !== 2'(f)) begin
            failures++;
            $display("FAIL rotation_frame%0d got full=%b sel=%b set=%0d expected 1 %0d %0d",
                     f, full, page_sel, mark_set, f % 2, f);
         end
         release_page(f % 2);
      end
      push_markers(0, 0);
      wait_drain(ok);
      checks++;
      if (!ok || mark_set !== 2'd0) begin
         failures++;
         $display("FAIL rotation_wrap got drained=%b set=%0d expected 1 0", ok, mark_set);
      end
   endtask

   task automatic test_stall();
      bit full;
      bit ok;
      int wr;
      logic [15:0] held;
      do_reset();
      push_markers(0, 0);
      fill_frame(0, FL - 4, 2, full);
      push_markers(1, 1);
      fill_frame(1, FL - 4, 2, full);
      checks++;
      if (!full || page_sel !== 1'b1) begin
         failures++;
         $display("FAIL stall_page1_full got full=%b sel=%b expected 1 1", full, page_sel);
      end
      wr = 0;
      repeat (6) begin
         tick();
         if (outWREN === 1'b1) wr++;
      end
      held = 16'hA5C3;
      send(held);
      if (outWREN === 1'b1) wr++;
      send(16'h1111);
      checks++;
      if (drop_cnt !== 8'd1) begin
         failures++;
         $display("FAIL stall_drop1 got %0d expected 1", drop_cnt);
      end
      send(16'h2222);
      if (outWREN === 1'b1) wr++;
      checks++;
      if (drop_cnt !== 8'd2 || wr != 0) begin
         failures++;
         $display("FAIL stall_drop2 got drop=%0d writes=%0d expected 2 0", drop_cnt, wr);
      end
      push_markers(0, 2);
      push_wr(4, held[11:0]);
      release_page(0);
      wait_drain(ok);
      checks++;
      if (!ok || drop_cnt !== 8'd2 || mark_set !== 2'd2) begin
         failures++;
         $display("FAIL stall_resume got drained=%b drop=%0d set=%0d expected 1 2 2", ok, drop_cnt, mark_set);
      end
   endtask

   task automatic test_same_cycle_release();
      bit full;
      bit ok;
      do_reset();
      push_markers(0, 0);
      fill_frame(0, FL - 4, 1, full);
      push_markers(1, 1);
      fill_frame(1, FL - 4, 1, full);
      push_markers(0, 2);
      release_page(0);
      checks++;
      if (outWREN !== 1'b0) begin
         failures++;
         $display("FAIL release_swap_idle got en=%b expected 0", outWREN);
      end
      tick();
      checks++;
      if (!full || outWREN !== 1'b1 || outWADR !== 10'd0 || mark_set !== 2'd2) begin
         failures++;
         $display("FAIL release_no_wait got full=%b en=%b addr=%0d set=%0d expected 1 1 0 2",
                  full, outWREN, outWADR, mark_set);
      end
      wait_drain(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL release_drain got %0d pending writes expected 0", sb.size());
      end
   endtask

   task automatic test_back_to_back();
      bit full;
      bit ok;
      logic [15:0] w;
      do_reset();
      push_markers(0, 0);
      fill_frame(0, FL - 4, 0, full);
      checks++;
      if (!full || drop_cnt !== 8'd0) begin
         failures++;
         $display("FAIL b2b_page0 got full=%b drop=%0d expected 1 0", full, drop_cnt);
      end
      // One word lands in the skid during the swap, then strobes refill it as it drains.
      push_markers(1, 1);
      w = 16'($urandom);
      push_wr(FL + 4, w[11:0]);
      send(w);
      repeat (4) tick();
      for (int j = 1; j < 4; j++) begin
         w = 16'($urandom);
         push_wr(FL + 4 + j, w[11:0]);
         send(w);
      end
      wait_drain(ok);
      checks++;
      if (!ok || drop_cnt !== 8'd0) begin
         failures++;
         $display("FAIL b2b_skid_refill got drained=%b drop=%0d expected 1 0", ok, drop_cnt);
      end
   endtask

   task automatic test_mid_frame_reset();
      bit full;
      bit ok;
      bit seen;
      do_reset();
      push_markers(0, 0);
      fill_frame(0, FL - 4, 1, full);
      release_page(0);
      push_markers(1, 1);
      fill_frame(1, 2, 1, full);
      wait_drain(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL midreset_prefill got %0d pending writes expected 0", sb.size());
      end
      reset = 1'b1;
      tick();
      checks++;
      if ({outWDAT, outWREN, outWADR, page_full, page_sel, mark_set, drop_cnt} !== 35'd0) begin
         failures++;
         $display("FAIL midreset_outputs got dat=%h en=%b addr=%0d full=%b sel=%b set=%0d drop=%0d expected all 0",
                  outWDAT, outWREN, outWADR, page_full, page_sel, mark_set, drop_cnt);
      end
      tick();
      sb.delete();
      reset = 1'b0;
      push_markers(0, 0);
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         tick();
         if (outWREN === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || outWADR !== 10'd0 || outWDAT !== 12'h7CD || mark_set !== 2'd0) begin
         failures++;
         $display("FAIL midreset_restart got seen=%b addr=%0d dat=%h set=%0d expected 1 0 7cd 0",
                  seen, outWADR, outWDAT, mark_set);
      end
      wait_drain(ok);
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_mark_rotation();
      test_stall();
      test_same_cycle_release();
      test_back_to_back();
      test_mid_frame_reset();
      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog simulation did not complete within time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
